// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter and sequencer for the shared 32-bit word memory
module mem_arbiter #(
  parameter int RD_LATENCY = 2,
  parameter int WAIT_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cart_req,
  input  logic        cart_we,
  input  logic [16:0] cart_addr,
  input  logic [3:0]  cart_be,
  input  logic [31:0] cart_wdata,
  output logic        cart_ack,
  output logic [31:0] cart_rdata,
  input  logic        usb_req,
  input  logic        usb_we,
  input  logic [16:0] usb_addr,
  input  logic [3:0]  usb_be,
  input  logic [31:0] usb_wdata,
  output logic        usb_ack,
  output logic [31:0] usb_rdata,
  output logic [1:0]  mem_cmd,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  output logic        busy,
  output logic        owner
);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, ACK
  } state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [3:0]  usb_wait_cnt, wait_n;
  logic        owner_n;
  logic [16:0] lat_addr, lat_addr_n;
  logic [3:0]  lat_be, lat_be_n;
  logic [31:0] lat_wdata, lat_wdata_n;
  logic [1:0]  mem_cmd_n;
  logic [16:0] mem_addr_n;
  logic [31:0] mem_wr_data_n;
  logic        cart_ack_n, usb_ack_n, busy_n;
  logic [31:0] cart_rdata_n, usb_rdata_n;

  logic        usb_win, cart_win;
  logic        sel_we;
  logic [16:0] sel_addr;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;
  logic [31:0] mask;
  logic [31:0] merged;

  // Byte mask from the latched enables and the read-modify-write merge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{lat_be[i]}};
    end
    merged = (mem_rd_data & ~mask) | (lat_wdata & mask);
  end

  // Arbitration, transaction sequencing and next values of every registered output.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    wait_n        = usb_wait_cnt;
    owner_n       = owner;
    lat_addr_n    = lat_addr;
    lat_be_n      = lat_be;
    lat_wdata_n   = lat_wdata;
    mem_cmd_n     = CMD_IDLE;
    mem_addr_n    = '0;
    mem_wr_data_n = '0;
    cart_ack_n    = 1'b0;
    usb_ack_n     = 1'b0;
    cart_rdata_n  = cart_rdata;
    usb_rdata_n   = usb_rdata;
    usb_win       = 1'b0;
    cart_win      = 1'b0;
    sel_we        = 1'b0;
    sel_addr      = '0;
    sel_be        = '0;
    sel_wdata     = '0;

    case (state)
      IDLE: begin
        usb_win  = usb_req && (!cart_req || (usb_wait_cnt >= 4'(WAIT_LIMIT)));
        cart_win = !usb_win && cart_req;
        if (!usb_req) wait_n = 4'd0;
        if (usb_win) begin
          wait_n    = 4'd0;
          owner_n   = 1'b1;
          sel_we    = usb_we;
          sel_addr  = usb_addr;
          sel_be    = usb_be;
          sel_wdata = usb_wdata;
        end else if (cart_win) begin
          if (usb_req && usb_wait_cnt != 4'hF) wait_n = usb_wait_cnt + 4'd1;
          owner_n   = 1'b0;
          sel_we    = cart_we;
          sel_addr  = cart_addr;
          sel_be    = cart_be;
          sel_wdata = cart_wdata;
        end
        if (usb_win || cart_win) begin
          lat_addr_n  = sel_addr;
          lat_be_n    = sel_be;
          lat_wdata_n = sel_wdata;
          cnt_n       = 3'd0;
          if (!sel_we) begin
            state_n    = RD;
            mem_cmd_n  = CMD_READ;
            mem_addr_n = sel_addr;
          end else if (sel_be == 4'hF) begin
            state_n       = WR;
            mem_cmd_n     = CMD_WRITE;
            mem_addr_n    = sel_addr;
            mem_wr_data_n = sel_wdata;
          end else if (sel_be == 4'h0) begin
            // Nothing to write: acknowledge without touching memory.
            state_n    = ACK;
            cart_ack_n = cart_win;
            usb_ack_n  = usb_win;
          end else begin
            state_n    = RMW_RD;
            mem_cmd_n  = CMD_READ;
            mem_addr_n = sel_addr;
          end
        end
      end
      RD: begin
        state_n = RD_WAIT;
        cnt_n   = 3'd1;
      end
      RD_WAIT: begin
        if (cnt == 3'(RD_LATENCY)) begin
          state_n = ACK;
          if (owner) begin
            usb_rdata_n = mem_rd_data;
            usb_ack_n   = 1'b1;
          end else begin
            cart_rdata_n = mem_rd_data;
            cart_ack_n   = 1'b1;
          end
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      RMW_RD: begin
        state_n = RMW_WAIT;
        cnt_n   = 3'd1;
      end
      RMW_WAIT: begin
        if (cnt == 3'(RD_LATENCY)) begin
          state_n       = WR;
          mem_cmd_n     = CMD_WRITE;
          mem_addr_n    = lat_addr;
          mem_wr_data_n = merged;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      WR: begin
        state_n    = ACK;
        cart_ack_n = !owner;
        usb_ack_n  = owner;
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      usb_wait_cnt <= '0;
      owner        <= 1'b0;
      lat_addr     <= '0;
      lat_be       <= '0;
      lat_wdata    <= '0;
      mem_cmd      <= CMD_IDLE;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      cart_ack     <= 1'b0;
      usb_ack      <= 1'b0;
      cart_rdata   <= '0;
      usb_rdata    <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      usb_wait_cnt <= wait_n;
      owner        <= owner_n;
      lat_addr     <= lat_addr_n;
      lat_be       <= lat_be_n;
      lat_wdata    <= lat_wdata_n;
      mem_cmd      <= mem_cmd_n;
      mem_addr     <= mem_addr_n;
      mem_wr_data  <= mem_wr_data_n;
      cart_ack     <= cart_ack_n;
      usb_ack      <= usb_ack_n;
      cart_rdata   <= cart_rdata_n;
      usb_rdata    <= usb_rdata_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency-accurate memory model
module tb_mem_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cart_req, cart_we;
  logic [16:0] cart_addr;
  logic [3:0]  cart_be;
  logic [31:0] cart_wdata;
  logic        cart_ack;
  logic [31:0] cart_rdata;
  logic        usb_req, usb_we;
  logic [16:0] usb_addr;
  logic [3:0]  usb_be;
  logic [31:0] usb_wdata;
  logic        usb_ack;
  logic [31:0] usb_rdata;
  logic [1:0]  mem_cmd;
  logic [16:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        busy, owner;

  mem_arbiter #(.RD_LATENCY(L), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cart_req(cart_req), .cart_we(cart_we), .cart_addr(cart_addr), .cart_be(cart_be),
    .cart_wdata(cart_wdata), .cart_ack(cart_ack), .cart_rdata(cart_rdata),
    .usb_req(usb_req), .usb_we(usb_we), .usb_addr(usb_addr), .usb_be(usb_be),
    .usb_wdata(usb_wdata), .usb_ack(usb_ack), .usb_rdata(usb_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int          c;
    logic [1:0]  cmd;
    logic [16:0] addr;
    logic [31:0] data;
    logic        ca;
    logic        ua;
    logic [31:0] crd;
    logic [31:0] urd;
  } ev_t;

  ev_t exp_q[$];
  logic [31:0] exp_crd = '0;
  logic [31:0] exp_urd = '0;

  function automatic void push(int c, logic [1:0] cmd, logic [16:0] addr, logic [31:0] data,
                               logic ca, logic ua);
    ev_t e;
    e.c = c; e.cmd = cmd; e.addr = addr; e.data = data;
    e.ca = ca; e.ua = ua; e.crd = exp_crd; e.urd = exp_urd;
    exp_q.push_back(e);
  endfunction

  // Memory model: writes land immediately, read data is driven only in the cycle it is due.
  logic [31:0] mem [int];
  logic        hv [0:7];
  logic [16:0] ha [0:7];
  initial begin
    for (int k = 0; k < 8; k++) begin hv[k] = 1'b0; ha[k] = '0; end
    mem_rd_data = 32'hBAD0BAD0;
  end
  always @(posedge clk) begin
    #1;
    for (int k = 7; k > 0; k--) begin hv[k] = hv[k-1]; ha[k] = ha[k-1]; end
    hv[0] = (mem_cmd == 2'b01);
    ha[0] = mem_addr;
    if (mem_cmd == 2'b10) mem[int'(mem_addr)] = mem_wr_data;
    if (hv[L]) mem_rd_data = mem.exists(int'(ha[L])) ? mem[int'(ha[L])] : 32'h0;
    else       mem_rd_data = 32'hBAD0BAD0;
  end

  // Monitor: every command or ack the DUT presents is matched against the next expected event.
  always @(posedge clk) begin
    #1;
    if (mem_cmd == 2'b00) begin
      n_cmp++;
      if (mem_addr != 0 || mem_wr_data != 0) begin
        n_fail++;
        $display("FAIL idle_zero cyc=%0d addr=%h data=%h required 0", cyc, mem_addr, mem_wr_data);
      end
    end
    if (mem_cmd != 2'b00 || cart_ack || usb_ack) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d cmd=%b addr=%h data=%h ca=%b ua=%b",
                 cyc, mem_cmd, mem_addr, mem_wr_data, cart_ack, usb_ack);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.c != cyc || e.cmd != mem_cmd || e.addr != mem_addr || e.data != mem_wr_data ||
            e.ca != cart_ack || e.ua != usb_ack || e.crd != cart_rdata || e.urd != usb_rdata) begin
          n_fail++;
          $display("FAIL event got cyc=%0d cmd=%b addr=%h data=%h ca=%b ua=%b crd=%h urd=%h required cyc=%0d cmd=%b addr=%h data=%h ca=%b ua=%b crd=%h urd=%h",
                   cyc, mem_cmd, mem_addr, mem_wr_data, cart_ack, usb_ack, cart_rdata, usb_rdata,
                   e.c, e.cmd, e.addr, e.data, e.ca, e.ua, e.crd, e.urd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [63:0] got, logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Drive a transaction in the current (idle) cycle, check busy/owner next cycle, wait for ack.
  task automatic txn(input logic side, input logic we, input logic [16:0] addr,
                     input logic [3:0] be, input logic [31:0] wdata);
    bit done;
    if (side) begin
      usb_req = 1; usb_we = we; usb_addr = addr; usb_be = be; usb_wdata = wdata;
    end else begin
      cart_req = 1; cart_we = we; cart_addr = addr; cart_be = be; cart_wdata = wdata;
    end
    tick();
    check("busy_owner", {62'b0, busy, owner}, {62'b0, 1'b1, side});
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (side ? usb_ack : cart_ack) done = 1;
      else tick();
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL ack_timeout side=%0d got no ack required ack", side);
    end
    cart_req = 0; usb_req = 0;
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int nack;
    rst_n = 0;
    cart_req = 0; cart_we = 0; cart_addr = '0; cart_be = '0; cart_wdata = '0;
    usb_req = 0;  usb_we = 0;  usb_addr = '0;  usb_be = '0;  usb_wdata = '0;
    mem[32'h10] = 32'hDEADBEEF;
    mem[32'h20] = 32'hAABBCCDD;
    tick(); tick(); tick();
    check("reset_state", {mem_cmd, mem_addr, mem_wr_data, cart_ack, usb_ack, busy, owner, 9'b0},
          64'h0);
    check("reset_rdata", {cart_rdata, usb_rdata}, 64'h0);
    rst_n = 1;
    tick(); tick();

    // Cart read
    t = cyc;
    push(t + 1, 2'b01, 17'h00010, 32'h0, 0, 0);
    exp_crd = 32'hDEADBEEF;
    push(t + 4, 2'b00, 17'h0, 32'h0, 1, 0);
    txn(0, 0, 17'h00010, 4'hF, 32'h0);

    // USB full write at top address
    t = cyc;
    push(t + 1, 2'b10, 17'h1FFFF, 32'h12345678, 0, 0);
    push(t + 2, 2'b00, 17'h0, 32'h0, 0, 1);
    txn(1, 1, 17'h1FFFF, 4'hF, 32'h12345678);
    check("owner_usb", {63'b0, owner}, 64'h1);

    // Cart read-modify-write
    t = cyc;
    push(t + 1, 2'b01, 17'h00020, 32'h0, 0, 0);
    push(t + 4, 2'b10, 17'h00020, 32'hAA22CC44, 0, 0);
    push(t + 5, 2'b00, 17'h0, 32'h0, 1, 0);
    txn(0, 1, 17'h00020, 4'b0101, 32'h11223344);
    check("owner_cart", {63'b0, owner}, 64'h0);

    // USB read back of the top address
    t = cyc;
    push(t + 1, 2'b01, 17'h1FFFF, 32'h0, 0, 0);
    exp_urd = 32'h12345678;
    push(t + 4, 2'b00, 17'h0, 32'h0, 0, 1);
    txn(1, 0, 17'h1FFFF, 4'h0, 32'h0);

    // USB write with no byte enables
    t = cyc;
    push(t + 1, 2'b00, 17'h0, 32'h0, 0, 1);
    txn(1, 1, 17'h00030, 4'h0, 32'hFFFFFFFF);
    check("busy_idle", {63'b0, busy}, 64'h0);

    // Both requesters held: C,C,C,C,U repeating
    t = cyc;
    for (int k = 0; k < 10; k++) begin
      push(t + 2 * k + 1, 2'b00, 17'h0, 32'h0, (k % 5) != 4, (k % 5) == 4);
    end
    cart_req = 1; cart_we = 1; cart_be = 4'h0; cart_addr = 17'h00040; cart_wdata = 32'h1;
    usb_req = 1;  usb_we = 1;  usb_be = 4'h0;  usb_addr = 17'h00050;  usb_wdata = 32'h2;
    nack = 0;
    for (int i = 0; i < 60 && nack < 10; i++) begin
      tick();
      if (cart_ack || usb_ack) nack++;
    end
    check("arb_ack_count", 64'(nack), 64'd10);
    cart_req = 0; usb_req = 0;
    tick(); tick();

    // Reset asserted while the RMW read is outstanding
    t = cyc;
    push(t + 1, 2'b01, 17'h00020, 32'h0, 0, 0);
    cart_req = 1; cart_we = 1; cart_addr = 17'h00020; cart_be = 4'b1000; cart_wdata = 32'h99000000;
    tick(); tick();
    #1 rst_n = 0;
    #1;
    check("async_reset", {mem_cmd, mem_addr, mem_wr_data, cart_ack, usb_ack, busy, owner, 9'b0},
          64'h0);
    check("async_reset_rdata", {cart_rdata, usb_rdata}, 64'h0);
    cart_req = 0;
    exp_crd = '0; exp_urd = '0;
    tick(); tick(); tick();
    rst_n = 1;
    tick(); tick();

    // Re-issued RMW completes normally
    t = cyc;
    push(t + 1, 2'b01, 17'h00020, 32'h0, 0, 0);
    push(t + 4, 2'b10, 17'h00020, 32'h9922CC44, 0, 0);
    push(t + 5, 2'b00, 17'h0, 32'h0, 1, 0);
    txn(0, 1, 17'h00020, 4'b1000, 32'h99000000);

    // Cart read back of the merged word
    t = cyc;
    push(t + 1, 2'b01, 17'h00020, 32'h0, 0, 0);
    exp_crd = 32'h9922CC44;
    push(t + 4, 2'b00, 17'h0, 32'h0, 1, 0);
    txn(0, 0, 17'h00020, 4'hF, 32'h0);

    for (int i = 0; i < 10; i++) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the shared 32-bit word memory (17-bit word address, CMD_IDLE/CMD_READ/CMD_WRITE command port).
- Grants the memory to one of two requesters, cart side and USB side, through a req/ack handshake.
- Sequences each transaction: plain read, full-word write, or read-modify-write for partial byte-enable writes.
- Fixed cart priority, with a starvation guard that forces a USB grant after a bounded number of lost arbitrations.

Parameters:
- RD_LATENCY, 2, cycles from the first cycle mem_cmd==CMD_READ is visible to the cycle mem_rd_data is valid (legal 1..7).
- WAIT_LIMIT, 4, number of consecutive cart grants while usb_req is pending before USB is forced (legal 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cart_req  in  1  cart request; cart_we/addr/be/wdata held stable until cart_ack
- cart_we  in  1  1=write, 0=read
- cart_addr  in  17  word address
- cart_be  in  4  byte enables; be[i] covers bits 8i+7:8i
- cart_wdata  in  32  write data
- cart_ack  out  1  one-cycle completion pulse
- cart_rdata  out  32  read data, valid with cart_ack, held until next cart read ack
- usb_req, usb_we, usb_addr, usb_be, usb_wdata, usb_ack, usb_rdata: identical set for the USB side
- mem_cmd  out  2  00 idle, 01 read, 10 write
- mem_addr  out  17  word address
- mem_wr_data  out  32  write data
- mem_rd_data  in  32  read data
- busy  out  1  high in every state except IDLE
- owner  out  1  0=cart, 1=usb; last granted requester

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; all outputs 0; usb_wait_cnt=0.
  - An in-flight transaction is abandoned and no ack is issued. Requesters re-issue after reset.
- All outputs are registered. mem_addr and mem_wr_data are 0 whenever mem_cmd is CMD_IDLE. mem_cmd is a one-cycle pulse.
- States: IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, ACK.
- Arbitration, evaluated only in IDLE:
  - usb wins if usb_req && (!cart_req || usb_wait_cnt >= WAIT_LIMIT).
  - Otherwise cart wins if cart_req.
  - The winner's fields are latched and owner is updated.
- usb_wait_cnt:
  - +1, saturating at 15, on a cart grant while usb_req=1.
  - Cleared on a USB grant or when usb_req=0 in IDLE.
- Transition out of IDLE at grant cycle T:
  - Read: to RD. mem_cmd=READ and mem_addr are visible at T+1.
  - Write with be=4'hF: to WR. mem_cmd=WRITE and wdata are visible at T+1.
  - Write with be=4'h0: straight to ACK, no memory access. ack is visible at T+1.
  - Write with any other be: to RMW_RD. mem_cmd=READ is visible at T+1.
- RD / RD_WAIT:
  - Counter waits RD_LATENCY cycles.
  - mem_rd_data is sampled at cycle T+1+RD_LATENCY into the owner's rdata, then go to ACK.
  - ack and rdata are visible at T+2+RD_LATENCY (T+4 at default).
- RMW_RD / RMW_WAIT:
  - Sample mem_rd_data at T+1+RD_LATENCY.
  - merged = (rd & ~mask) | (wdata & mask), where mask byte i = {8{be[i]}}.
  - Go to WR. mem_cmd=WRITE with merged data is visible at T+2+RD_LATENCY.
- WR: mem_cmd returns to IDLE next cycle; go to ACK. ack is visible one cycle after the write command.
  - Full write: ack at T+2.
  - RMW: ack at T+3+RD_LATENCY (T+5 at default).
- ACK:
  - Owner's ack is high for exactly one cycle.
  - Next state is IDLE, which samples req on the following cycle.
  - Requesters must drop req or present a new transaction by then.
- The non-granted requester's req is ignored until IDLE. Its ack stays 0.
- Back-to-back: with both req held continuously, grants alternate at a maximum of one USB per WAIT_LIMIT+1 grants.
- rdata of the non-owner is never modified.
- Address is a word address; no wrap logic. 17'h1FFFF is passed through unchanged.

Test Plan:
- Cart read, addr 17'h00010, memory model returns 32'hDEADBEEF with RD_LATENCY=2 -> mem_cmd=01 at T+1 only; cart_ack and cart_rdata=DEADBEEF at T+4; usb_ack stays 0.
- USB write, be=F, addr 17'h1FFFF, wdata 32'h12345678 -> mem_cmd=10 with addr 1FFFF and data 12345678 at T+1; usb_ack at T+2; then mem_addr/mem_wr_data return to 0.
- Cart RMW, mem word 32'hAABBCCDD, be=4'b0101, wdata 32'h11223344 -> read at T+1, write of 32'hAA22CC44 at T+4, cart_ack at T+5.
- Both req held continuously, WAIT_LIMIT=4 -> grant order C,C,C,C,U,C,C,C,C,U; usb_wait_cnt clears after each U.
- Write with be=0 -> no mem_cmd activity; ack at T+1.
- rst_n pulsed low during RMW_WAIT -> mem_cmd=00 and all outputs 0 immediately, no ack; after release a re-issued request completes normally.
